// File: rtl/ram_arbiter.sv
// Arbitrates a write requester and a read requester onto one single-port RAM.
// Writes win conflicts until a read has waited MAXWAIT cycles; RAM signals are registered.
module ram_arbiter #(
    parameter int DATASIZE = 12,
    parameter int ADDRSIZE = 7,
    parameter int MAXWAIT  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_req,
    input  logic [ADDRSIZE-1:0] wr_addr,
    input  logic [DATASIZE-1:0] wr_data,
    output logic                wr_gnt,
    input  logic                rd_req,
    input  logic [ADDRSIZE-1:0] rd_addr,
    output logic                rd_gnt,
    output logic [DATASIZE-1:0] rd_data,
    output logic                rd_valid,
    output logic                ram_enw,
    output logic [ADDRSIZE-1:0] ram_addr,
    output logic [DATASIZE-1:0] ram_datai,
    input  logic [DATASIZE-1:0] ram_datao
);

    localparam int WW = (MAXWAIT < 1) ? 1 : $clog2(MAXWAIT + 1);

    typedef enum logic [1:0] {IDLE, WR, RD} state_t;

    state_t        state, state_nxt;
    logic [WW-1:0] wait_cnt, wait_nxt;
    logic          wait_full;

    assign wait_full = (wait_cnt == WW'(MAXWAIT));

    always_comb begin
        wr_gnt    = 1'b0;
        rd_gnt    = 1'b0;
        state_nxt = IDLE;
        wait_nxt  = '0;
        // Grants are gated by reset so they read low while rst_n is asserted.
        if (rst_n) begin
            if (wr_req && !(rd_req && wait_full))
                wr_gnt = 1'b1;
            else if (rd_req)
                rd_gnt = 1'b1;
        end
        if (wr_gnt)
            state_nxt = WR;
        else if (rd_gnt)
            state_nxt = RD;
        if (rd_req && !rd_gnt)
            wait_nxt = wait_full ? wait_cnt : wait_cnt + WW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            ram_enw   <= 1'b0;
            ram_addr  <= '0;
            ram_datai <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            ram_enw  <= wr_gnt;
            if (wr_gnt) begin
                ram_addr  <= wr_addr;
                ram_datai <= wr_data;
            end else if (rd_gnt) begin
                ram_addr <= rd_addr;
            end
            // RD means ram_addr holds the read address this cycle.
            rd_valid <= (state == RD);
            if (state == RD)
                rd_data <= ram_datao;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: behavioural RAM, grant model and
// a read-data scoreboard, plus vector table and reset-abort sequences.
module tb_ram_arbiter;

    localparam int DW = 12;
    localparam int AW = 7;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_req, rd_req;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data;
    logic          wr_gnt, rd_gnt, rd_valid, ram_enw;
    logic [DW-1:0] rd_data, ram_datai, ram_datao;
    logic [AW-1:0] ram_addr;

    ram_arbiter #(.DATASIZE(DW), .ADDRSIZE(AW), .MAXWAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .ram_enw(ram_enw), .ram_addr(ram_addr), .ram_datai(ram_datai),
        .ram_datao(ram_datao)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem     [128];
    logic [DW-1:0] ref_mem [128];

    always @(posedge clk) if (ram_enw) mem[ram_addr] <= ram_datai;
    assign ram_datao = mem[ram_addr];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [DW-1:0] data;
        int unsigned   cyc;
    } sb_t;

    sb_t           sb[$];
    int unsigned   cyc = 0;
    int unsigned   n_rv = 0;
    logic          mon_en = 1'b0;
    int unsigned   mcnt;
    logic          pw, pr, exp_wr, exp_rd, exp_v;
    logic [AW-1:0] pwa, pra, ma;
    logic [DW-1:0] pwd, md, last_rd;

    // Reference model: grants, RAM-side outputs and read data, one cycle at a time.
    always @(negedge clk) begin
        if (!mon_en) begin
            mcnt = 0; pw = 0; pr = 0; ma = '0; md = '0; last_rd = '0;
            sb.delete();
        end else begin
            if (pw) begin ma = pwa; md = pwd; end
            if (pr) ma = pra;
            check("ram_enw", ram_enw, pw);
            check("ram_addr", ram_addr, ma);
            check("ram_datai", ram_datai, md);

            while (sb.size() > 0 && sb[0].cyc + 2 < cyc) void'(sb.pop_front());
            exp_v = (sb.size() > 0 && sb[0].cyc + 2 == cyc);
            check("rd_valid", rd_valid, exp_v);
            if (rd_valid) n_rv++;
            if (exp_v) begin
                check("rd_data", rd_data, sb[0].data);
                last_rd = sb[0].data;
                void'(sb.pop_front());
            end else if (!rd_valid) begin
                check("rd_data_hold", rd_data, last_rd);
            end

            exp_wr = wr_req && !(rd_req && mcnt == MW);
            exp_rd = rd_req && !exp_wr;
            check("wr_gnt", wr_gnt, exp_wr);
            check("rd_gnt", rd_gnt, exp_rd);
            if (exp_wr) ref_mem[wr_addr] = wr_data;
            if (exp_rd) sb.push_back('{data: ref_mem[rd_addr], cyc: cyc});
            if (rd_req && !exp_rd) mcnt = (mcnt == MW) ? mcnt : mcnt + 1;
            else mcnt = 0;
            pw = exp_wr; pwa = wr_addr; pwd = wr_data;
            pr = exp_rd; pra = rd_addr;
        end
        cyc++;
    end

    // Called at posedge+1; holds the request for one cycle.
    task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic r, input logic [AW-1:0] ra);
        wr_req = w; wr_addr = wa; wr_data = wd; rd_req = r; rd_addr = ra;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic check_reset_outputs(input string tag);
        wr_req = 1'b1; rd_req = 1'b1;
        #1;
        check({tag, "_wr_gnt"}, wr_gnt, 1'b0);
        check({tag, "_rd_gnt"}, rd_gnt, 1'b0);
        check({tag, "_ram_enw"}, ram_enw, 1'b0);
        check({tag, "_ram_addr"}, ram_addr, '0);
        check({tag, "_ram_datai"}, ram_datai, '0);
        check({tag, "_rd_data"}, rd_data, '0);
        check({tag, "_rd_valid"}, rd_valid, 1'b0);
        wr_req = 1'b0; rd_req = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;
    endtask

    typedef struct {
        logic          w;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          r;
        logic [AW-1:0] ra;
        logic          ewg;
        logic          erg;
    } vec_t;

    vec_t          vt[$];
    logic [DW-1:0] old;
    int unsigned   rv0;

    initial begin
        for (int i = 0; i < 128; i++) begin mem[i] = '0; ref_mem[i] = '0; end
        rst_n = 1'b0;
        wr_req = 0; rd_req = 0; wr_addr = '0; rd_addr = '0; wr_data = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("init");
        release_reset();

        // Single write then read of address 5; requests start on the first edge after reset.
        drive(1'b1, 7'd5, 12'hABC, 1'b0, '0);
        check("w5_enw", ram_enw, 1'b1);
        check("w5_addr", ram_addr, 7'd5);
        check("w5_data", ram_datai, 12'hABC);
        idle(1);
        drive(1'b0, '0, '0, 1'b1, 7'd5);
        idle(1);
        check("r5_valid", rd_valid, 1'b1);
        check("r5_data", rd_data, 12'hABC);
        idle(5);

        // Conflict pattern: four writes, then a forced read, repeating.
        for (int i = 0; i < 10; i++)
            vt.push_back('{1'b1, 7'h10, 12'h111, 1'b1, 7'd5, (i % 5) != 4, (i % 5) == 4});
        vt.push_back('{1'b0, 7'h00, 12'h000, 1'b0, 7'h00, 1'b0, 1'b0});
        vt.push_back('{1'b1, 7'h20, 12'h222, 1'b0, 7'h00, 1'b1, 1'b0});
        vt.push_back('{1'b1, 7'h21, 12'h333, 1'b0, 7'h00, 1'b1, 1'b0});
        vt.push_back('{1'b0, 7'h00, 12'h000, 1'b1, 7'h20, 1'b0, 1'b1});
        vt.push_back('{1'b0, 7'h00, 12'h000, 1'b1, 7'h21, 1'b0, 1'b1});
        vt.push_back('{1'b1, 7'h22, 12'h444, 1'b1, 7'h20, 1'b1, 1'b0});
        vt.push_back('{1'b0, 7'h00, 12'h000, 1'b1, 7'h20, 1'b0, 1'b1});
        vt.push_back('{1'b0, 7'h00, 12'h000, 1'b0, 7'h00, 1'b0, 1'b0});
        for (int i = 0; i < vt.size(); i++) begin
            wr_req = vt[i].w; wr_addr = vt[i].wa; wr_data = vt[i].wd;
            rd_req = vt[i].r; rd_addr = vt[i].ra;
            @(negedge clk);
            check($sformatf("vec%0d_wr_gnt", i), wr_gnt, vt[i].ewg);
            check($sformatf("vec%0d_rd_gnt", i), rd_gnt, vt[i].erg);
            check($sformatf("vec%0d_excl", i), wr_gnt & rd_gnt, 1'b0);
            @(posedge clk); #1;
        end
        idle(4);

        // Read-after-write with no stall at the top address.
        drive(1'b1, 7'h7F, 12'h123, 1'b0, '0);
        drive(1'b0, '0, '0, 1'b1, 7'h7F);
        idle(1);
        check("raw_valid", rd_valid, 1'b1);
        check("raw_data", rd_data, 12'h123);
        idle(4);

        // Full sweep: 128 writes then 128 back-to-back reads.
        for (int i = 0; i < 128; i++) drive(1'b1, AW'(i), DW'(i), 1'b0, '0);
        rv0 = n_rv;
        for (int i = 0; i < 128; i++) drive(1'b0, '0, '0, 1'b1, AW'(i));
        idle(4);
        check("sweep_pulses", n_rv - rv0, 128);
        check("sb_drained", sb.size(), 0);

        // Reset during the ram_enw cycle aborts the write.
        old = ref_mem[3];
        drive(1'b1, 7'd3, 12'h5A5, 1'b0, '0);
        check("abw_enw_before", ram_enw, 1'b1);
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abw_enw_async", ram_enw, 1'b0);
        check_reset_outputs("abw");
        ref_mem[3] = old;
        release_reset();
        drive(1'b0, '0, '0, 1'b1, 7'd3);
        idle(4);

        // Reset during the RD cycle suppresses rd_valid.
        drive(1'b0, '0, '0, 1'b1, 7'd5);
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abr");
        release_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abr_no_valid", rd_valid, 1'b0);
        end
        @(posedge clk); #1;
        idle(3);
        check("sb_final", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
